// File: rtl/memory_encoder.sv
// memory_encoder: encodes 24-bit RGB pixels to 3-3-2 codes, packs two codes
// per 16-bit word (first pixel in the high byte) and writes each word to frame
// memory through a request/acknowledge handshake.
module memory_encoder #(
    parameter int FRAME_WORDS = 9600,
    parameter int ADDR_WIDTH  = 14
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  PIX_VALID,
    input  logic [23:0]           PIX_RGB,
    output logic                  PIX_READY,
    input  logic                  FRAME_START,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [15:0]           MEM_IN,
    input  logic                  MEM_WACK,
    output logic                  FRAME_DONE
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_SECOND = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    // 3-3-2 truncation of the top colour bits, no rounding
    function automatic logic [7:0] encode_rgb(input logic [2:0] r,
                                              input logic [2:0] g,
                                              input logic [1:0] b);
        return {r, g, b};
    endfunction

    state_t                state_r, state_s;
    logic [7:0]            high_r, high_s;
    logic [15:0]           word_r, word_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic                  restart_r, restart_s;
    logic                  done_r, done_s;
    logic                  accept_s;
    logic [7:0]            code_s;
    logic                  unused_rgb_s;

    // Low colour bits are dropped by the encoding
    assign unused_rgb_s = ^{PIX_RGB[20:16], PIX_RGB[12:8], PIX_RGB[5:0]};

    assign code_s   = encode_rgb(PIX_RGB[23:21], PIX_RGB[15:13], PIX_RGB[7:6]);
    assign accept_s = PIX_VALID && (state_r != ST_WRITE);

    // Next-state logic: pixel pairing, write handshake, address and restart handling
    always_comb begin
        state_s   = state_r;
        high_s    = high_r;
        word_s    = word_r;
        addr_s    = addr_r;
        restart_s = restart_r;
        done_s    = 1'b0;
        case (state_r)
            ST_FIRST, ST_SECOND: begin
                if (FRAME_START) begin
                    // Drop any half-built pair and restart the frame
                    addr_s  = ADDR_ZERO;
                    state_s = ST_FIRST;
                end else begin
                    state_s = state_r;
                end
                if (accept_s) begin
                    if (FRAME_START || (state_r == ST_FIRST)) begin
                        high_s  = code_s;
                        state_s = ST_SECOND;
                    end else begin
                        word_s  = {high_r, code_s};
                        state_s = ST_WRITE;
                    end
                end else begin
                    high_s = high_r;
                end
            end
            ST_WRITE: begin
                if (FRAME_START) begin
                    restart_s = 1'b1;
                end else begin
                    restart_s = restart_r;
                end
                if (MEM_WACK) begin
                    state_s = ST_FIRST;
                    if (restart_r || FRAME_START) begin
                        // Restart requested during the write: no frame-done
                        addr_s    = ADDR_ZERO;
                        restart_s = 1'b0;
                    end else if (addr_r == LAST_ADDR) begin
                        addr_s = ADDR_ZERO;
                        done_s = 1'b1;
                    end else begin
                        addr_s = addr_r + ADDR_ONE;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
            default: begin
                state_s   = ST_FIRST;
                restart_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= ST_FIRST;
            high_r    <= 8'h00;
            word_r    <= 16'h0000;
            addr_r    <= ADDR_ZERO;
            restart_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            high_r    <= high_s;
            word_r    <= word_s;
            addr_r    <= addr_s;
            restart_r <= restart_s;
            done_r    <= done_s;
        end
    end

    assign PIX_READY  = (state_r != ST_WRITE);
    assign MEM_WE     = (state_r == ST_WRITE);
    assign MEM_ADDR   = addr_r;
    assign MEM_IN     = word_r;
    assign FRAME_DONE = done_r;

endmodule
